// File: rtl/st2110_pkg.sv
// st2110_pkg: shared state type, TX beat width and source index type for the ST 2110 TX arbiter
package st2110_pkg;
  localparam int ETH_TX_DATA_W = 64;
  localparam int MAX_SRC = 8;
  typedef enum logic [1:0] {IDLE, XFER, GAP} arb_state_e;
  typedef logic [$clog2(MAX_SRC)-1:0] src_idx_t;
endpackage

// File: rtl/st2110_rr_pick.sv
// st2110_rr_pick: combinational round-robin picker starting one past last_grant
//   req        in  per-source request
//   last_grant in  index granted most recently
//   gnt_idx    out first requester scanning last_grant+1, +2, ... modulo NUM_SRC
//   gnt_any    out at least one request present
module st2110_rr_pick
  import st2110_pkg::*;
#(
  parameter int NUM_SRC = 3
) (
  input  logic [NUM_SRC-1:0]         req,
  input  logic [$clog2(NUM_SRC)-1:0] last_grant,
  output logic [$clog2(NUM_SRC)-1:0] gnt_idx,
  output logic                       gnt_any
);
  localparam int IW = $clog2(NUM_SRC);
  src_idx_t cand;
  // Walk the scan order backwards so the nearest requester is the last one written.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand = '0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      if (req[(int'(last_grant) + k) % NUM_SRC]) begin
        cand = src_idx_t'((int'(last_grant) + k) % NUM_SRC);
        gnt_idx = cand[IW-1:0];
        gnt_any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/st2110_tx_arbiter.sv
// st2110_tx_arbiter: packet-level arbiter sharing one Ethernet TX path between RTP sources
//   clk, rst_n                  clock, async active-low reset
//   src_data/valid/last/ready   per-source beat streams (source i at [i*DATA_W +: DATA_W])
//   tx_data/valid/last/ready    forwarded stream to the Ethernet TX encapsulator
//   tx_src_id                   index of the granted source
//   busy                        transfer or idle gap in progress
//   pkt_done                    one-cycle pulse the cycle after each packet's last beat
module st2110_tx_arbiter
  import st2110_pkg::*;
#(
  parameter int NUM_SRC   = 3,
  parameter int DATA_W    = ETH_TX_DATA_W,
  parameter int MIN_GAP   = 3,
  parameter bit PRIO_SRC0 = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_SRC*DATA_W-1:0]   src_data,
  input  logic [NUM_SRC-1:0]          src_valid,
  input  logic [NUM_SRC-1:0]          src_last,
  output logic [NUM_SRC-1:0]          src_ready,
  output logic [DATA_W-1:0]           tx_data,
  output logic                        tx_valid,
  output logic                        tx_last,
  input  logic                        tx_ready,
  output logic [$clog2(NUM_SRC)-1:0]  tx_src_id,
  output logic                        busy,
  output logic                        pkt_done
);
  localparam int IW = $clog2(NUM_SRC);
  localparam int GW = MIN_GAP > 1 ? $clog2(MIN_GAP) : 1;
  arb_state_e state_q, state_d;
  logic [IW-1:0] grant_q, grant_d, last_grant_q, last_grant_d, rr_idx, pick_idx;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic pkt_done_q, pkt_done_d, rr_any, xfer, beat, gap_end;
  st2110_rr_pick #(.NUM_SRC(NUM_SRC)) u_pick (
    .req       (src_valid),
    .last_grant(last_grant_q),
    .gnt_idx   (rr_idx),
    .gnt_any   (rr_any)
  );
  // Source 0 overrides round-robin only when strict priority is enabled.
  assign pick_idx  = (PRIO_SRC0 && src_valid[0]) ? '0 : rr_idx;
  assign xfer      = state_q == XFER;
  assign beat      = xfer && src_valid[grant_q] && tx_ready;
  assign gap_end   = gap_cnt_q == GW'(MIN_GAP - 1);
  assign tx_valid  = xfer && src_valid[grant_q];
  assign tx_last   = xfer && src_last[grant_q];
  assign tx_data   = xfer ? src_data[grant_q*DATA_W +: DATA_W] : '0;
  assign src_ready = (xfer && tx_ready) ? NUM_SRC'(1) << grant_q : '0;
  assign tx_src_id = grant_q;
  assign busy      = state_q != IDLE;
  assign pkt_done  = pkt_done_q;
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_grant_d = last_grant_q;
    gap_cnt_d = '0;
    pkt_done_d = beat && src_last[grant_q];
    case (state_q)
      IDLE: if (rr_any) begin
        state_d = XFER;
        grant_d = pick_idx;
      end
      XFER: if (pkt_done_d) begin
        state_d = MIN_GAP > 0 ? GAP : IDLE;
        last_grant_d = grant_q;
      end
      GAP: begin
        gap_cnt_d = gap_end ? '0 : gap_cnt_q + 1'b1;
        state_d = gap_end ? IDLE : GAP;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_grant_q <= IW'(NUM_SRC - 1);
      gap_cnt_q <= '0;
      pkt_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_grant_q <= last_grant_d;
      gap_cnt_q <= gap_cnt_d;
      pkt_done_q <= pkt_done_d;
    end
  end
endmodule

// File: tb/tb_st2110_tx_arbiter.sv
// tb_st2110_tx_arbiter: randomized scenario bench for st2110_tx_arbiter against a packet-level model
module tb_st2110_tx_arbiter;
  localparam int N = 3;
  localparam int DW = 64;
  logic clk = 1'b0;
  logic rst_n;
  logic sel;
  logic [N*DW-1:0] src_data;
  logic [N-1:0] src_valid, src_last, src_ready, a_ready, b_ready;
  logic tx_ready;
  logic [DW-1:0] d [N];
  logic [DW-1:0] tx_data, a_data, b_data;
  logic tx_valid, a_valid, b_valid, tx_last, a_last, b_last;
  logic busy, a_busy, b_busy, pkt_done, a_done, b_done;
  logic [1:0] tx_src_id, a_id, b_id;
  always #5 clk = ~clk;
  assign src_data  = {d[2], d[1], d[0]};
  assign src_ready = sel ? b_ready : a_ready;
  assign tx_data   = sel ? b_data : a_data;
  assign tx_valid  = sel ? b_valid : a_valid;
  assign tx_last   = sel ? b_last : a_last;
  assign tx_src_id = sel ? b_id : a_id;
  assign busy      = sel ? b_busy : a_busy;
  assign pkt_done  = sel ? b_done : a_done;
  st2110_tx_arbiter #(.NUM_SRC(N), .DATA_W(DW), .MIN_GAP(3), .PRIO_SRC0(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .src_data(src_data), .src_valid(src_valid), .src_last(src_last),
    .src_ready(a_ready), .tx_data(a_data), .tx_valid(a_valid), .tx_last(a_last),
    .tx_ready(tx_ready), .tx_src_id(a_id), .busy(a_busy), .pkt_done(a_done)
  );
  st2110_tx_arbiter #(.NUM_SRC(N), .DATA_W(DW), .MIN_GAP(0), .PRIO_SRC0(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .src_data(src_data), .src_valid(src_valid), .src_last(src_last),
    .src_ready(b_ready), .tx_data(b_data), .tx_valid(b_valid), .tx_last(b_last),
    .tx_ready(tx_ready), .tx_src_id(b_id), .busy(b_busy), .pkt_done(b_done)
  );
  int checks = 0;
  int errors = 0;
  int m_owner, m_gap, m_last, m_grant, m_prio, m_gapp;
  bit m_done;
  int rem [N];
  int npk [N];
  int len [N];
  int hold [N];
  int acc [N];
  bit rnd_len, rnd_rdy, tog_rdy, stalled, in_pkt, prev_stall;
  int stall_src, stall_at, stall_len, stall_obs, bad_rdy;
  int cyc, n_beats, n_done, n_last, last_at, held_bad, held_cnt;
  logic [DW-1:0] prev_data;
  int grants[$];
  int starts[$];
  int busyq[$];
  function automatic int pick();
    if (m_prio != 0 && src_valid[0]) return 0;
    for (int k = 1; k <= N; k++) if (src_valid[(m_last + k) % N]) return (m_last + k) % N;
    return -1;
  endfunction
  function automatic bit all_idle();
    bit r;
    r = (m_owner < 0) && (m_gap == 0);
    for (int i = 0; i < N; i++) if (rem[i] != 0 || npk[i] != 0) r = 1'b0;
    return r;
  endfunction
  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (rem[i] == 0 && npk[i] > 0) begin
        rem[i] = rnd_len ? int'($urandom_range(1, 5)) : len[i];
        npk[i]--;
        d[i] = {$urandom, $urandom};
      end
      if (hold[i] > 0) begin
        src_valid[i] = 1'b0;
        hold[i]--;
      end else src_valid[i] = rem[i] > 0;
      src_last[i] = rem[i] == 1;
    end
  endtask
  task automatic do_reset(input logic s);
    sel = s;
    rst_n = 1'b0;
    m_owner = -1; m_gap = 0; m_last = N - 1; m_grant = 0; m_done = 1'b0;
    m_prio = s ? 1 : 0;
    m_gapp = s ? 0 : 3;
    for (int i = 0; i < N; i++) begin
      rem[i] = 0; npk[i] = 0; hold[i] = 0; acc[i] = 0; len[i] = 4;
      d[i] = {$urandom, $urandom};
    end
    src_valid = '0; src_last = '0; tx_ready = 1'b1;
    rnd_len = 0; rnd_rdy = 0; tog_rdy = 0; stalled = 0; in_pkt = 0; prev_stall = 0;
    stall_src = -1; stall_at = 0; stall_len = 0; stall_obs = 0; bad_rdy = 0;
    cyc = 0; n_beats = 0; n_done = 0; n_last = 0; last_at = 0; held_bad = 0; held_cnt = 0;
    grants.delete(); starts.delete(); busyq.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  task automatic step();
    bit xf;
    logic ev, el;
    logic [N-1:0] er, acc_now;
    logic [DW-1:0] ed;
    @(negedge clk);
    xf = m_owner >= 0;
    ev = xf ? src_valid[m_owner] : 1'b0;
    el = xf ? src_last[m_owner] : 1'b0;
    ed = xf ? d[m_owner] : '0;
    er = '0;
    if (xf && tx_ready) er[m_owner] = 1'b1;
    checks += 7;
    if (tx_valid !== ev) begin errors++; $display("FAIL tx_valid cyc=%0d got=%b exp=%b", cyc, tx_valid, ev); end
    if (tx_last !== el) begin errors++; $display("FAIL tx_last cyc=%0d got=%b exp=%b", cyc, tx_last, el); end
    if (tx_data !== ed) begin errors++; $display("FAIL tx_data cyc=%0d got=%h exp=%h", cyc, tx_data, ed); end
    if (src_ready !== er) begin errors++; $display("FAIL src_ready cyc=%0d got=%b exp=%b", cyc, src_ready, er); end
    if (tx_src_id !== 2'(m_grant)) begin errors++; $display("FAIL tx_src_id cyc=%0d got=%0d exp=%0d", cyc, tx_src_id, m_grant); end
    if (busy !== (xf || m_gap > 0)) begin errors++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, xf || m_gap > 0); end
    if (pkt_done !== m_done) begin errors++; $display("FAIL pkt_done cyc=%0d got=%b exp=%b", cyc, pkt_done, m_done); end
    if (tx_valid && tx_ready) begin
      n_beats++;
      if (!in_pkt) begin grants.push_back(int'(tx_src_id)); starts.push_back(cyc); end
      in_pkt = !tx_last;
      if (tx_last) begin n_last++; last_at = n_beats; end
    end
    if (prev_stall) begin held_cnt++; if (tx_data !== prev_data) held_bad++; end
    prev_stall = tx_valid && !tx_ready;
    prev_data = tx_data;
    if (pkt_done) n_done++;
    busyq.push_back(int'(busy));
    if (stall_src >= 0 && busy && !tx_valid && rem[stall_src] > 0 && acc[stall_src] == stall_at) begin
      stall_obs++;
      if ((src_ready & ~(N'(1) << stall_src)) != 0) bad_rdy++;
    end
    acc_now = src_valid & src_ready;
    @(posedge clk);
    m_done = 1'b0;
    if (xf) begin
      if (src_valid[m_owner] && tx_ready && src_last[m_owner]) begin
        m_done = 1'b1; m_last = m_owner; m_owner = -1; m_gap = m_gapp;
      end
    end else if (m_gap > 0) m_gap--;
    else if (src_valid != 0) begin m_owner = pick(); m_grant = m_owner; end
    for (int i = 0; i < N; i++) if (acc_now[i]) begin
      rem[i]--; acc[i]++;
      d[i] = {$urandom, $urandom};
      if (i == stall_src && !stalled && acc[i] == stall_at) begin hold[i] = stall_len; stalled = 1'b1; end
    end
    cyc++;
    #1;
    if (tog_rdy) tx_ready = ~tx_ready;
    else if (rnd_rdy) tx_ready = $urandom_range(0, 3) != 0;
    drive();
  endtask
  task automatic run(input int max);
    int c = 0;
    while (!all_idle() && c < max) begin step(); c++; end
    step(); step();
    checks++;
    if (!all_idle()) begin errors++; $display("FAIL timeout cyc=%0d got=busy exp=idle", cyc); end
  endtask
  task automatic test_reset();
    rst_n = 1'b1; sel = 1'b0;
    #1 rst_n = 1'b0;
    src_valid = '1; src_last = '0; tx_ready = 1'b1;
    for (int i = 0; i < N; i++) d[i] = {$urandom, $urandom};
    #2;
    checks += 12;
    if (a_valid !== 1'b0) begin errors++; $display("FAIL rst_a_valid got=%b exp=0", a_valid); end
    if (a_last !== 1'b0) begin errors++; $display("FAIL rst_a_last got=%b exp=0", a_last); end
    if (a_ready !== '0) begin errors++; $display("FAIL rst_a_ready got=%b exp=0", a_ready); end
    if (a_busy !== 1'b0) begin errors++; $display("FAIL rst_a_busy got=%b exp=0", a_busy); end
    if (a_done !== 1'b0) begin errors++; $display("FAIL rst_a_done got=%b exp=0", a_done); end
    if (a_id !== '0) begin errors++; $display("FAIL rst_a_id got=%0d exp=0", a_id); end
    if (b_valid !== 1'b0) begin errors++; $display("FAIL rst_b_valid got=%b exp=0", b_valid); end
    if (b_last !== 1'b0) begin errors++; $display("FAIL rst_b_last got=%b exp=0", b_last); end
    if (b_ready !== '0) begin errors++; $display("FAIL rst_b_ready got=%b exp=0", b_ready); end
    if (b_busy !== 1'b0) begin errors++; $display("FAIL rst_b_busy got=%b exp=0", b_busy); end
    if (b_done !== 1'b0) begin errors++; $display("FAIL rst_b_done got=%b exp=0", b_done); end
    if (b_id !== '0) begin errors++; $display("FAIL rst_b_id got=%0d exp=0", b_id); end
  endtask
  task automatic test_round_robin();
    int eg[4] = '{0, 1, 2, 0};
    int es[4] = '{1, 9, 17, 25};
    do_reset(1'b0);
    npk[0] = 2; npk[1] = 1; npk[2] = 1;
    drive();
    run(80);
    checks += 2;
    if (grants.size() != 4) begin errors++; $display("FAIL rr_count got=%0d exp=4", grants.size()); end
    if (n_done != 4) begin errors++; $display("FAIL rr_pkt_done got=%0d exp=4", n_done); end
    for (int i = 0; i < 4 && i < grants.size(); i++) begin
      checks += 2;
      if (grants[i] != eg[i]) begin errors++; $display("FAIL rr_grant%0d got=%0d exp=%0d", i, grants[i], eg[i]); end
      if (starts[i] != es[i]) begin errors++; $display("FAIL rr_start%0d got=%0d exp=%0d", i, starts[i], es[i]); end
    end
  endtask
  task automatic test_priority();
    int eg[3] = '{1, 0, 2};
    do_reset(1'b1);
    npk[1] = 1; npk[2] = 1;
    drive();
    step(); step();
    npk[0] = 1;
    run(80);
    checks++;
    if (grants.size() != 3) begin errors++; $display("FAIL prio_count got=%0d exp=3", grants.size()); end
    for (int i = 0; i < 3 && i < grants.size(); i++) begin
      checks++;
      if (grants[i] != eg[i]) begin errors++; $display("FAIL prio_grant%0d got=%0d exp=%0d", i, grants[i], eg[i]); end
    end
  endtask
  task automatic test_valid_drop();
    do_reset(1'b0);
    npk[0] = 1; npk[2] = 1; len[2] = 2;
    stall_src = 0; stall_at = 2; stall_len = 5;
    drive();
    run(80);
    checks += 4;
    if (stall_obs != 5) begin errors++; $display("FAIL drop_stall_cycles got=%0d exp=5", stall_obs); end
    if (bad_rdy != 0) begin errors++; $display("FAIL drop_other_ready got=%0d exp=0", bad_rdy); end
    if (n_beats != 6) begin errors++; $display("FAIL drop_beats got=%0d exp=6", n_beats); end
    if (grants.size() != 2 || grants[0] != 0) begin errors++; $display("FAIL drop_order got=%0d exp=0", grants.size() > 0 ? grants[0] : -1); end
  endtask
  task automatic test_ready_toggle();
    do_reset(1'b0);
    npk[1] = 1;
    tog_rdy = 1'b1;
    drive();
    run(60);
    checks += 5;
    if (n_beats != 4) begin errors++; $display("FAIL tog_beats got=%0d exp=4", n_beats); end
    if (n_last != 1) begin errors++; $display("FAIL tog_last_count got=%0d exp=1", n_last); end
    if (last_at != 4) begin errors++; $display("FAIL tog_last_beat got=%0d exp=4", last_at); end
    if (held_bad != 0) begin errors++; $display("FAIL tog_data_held got=%0d exp=0", held_bad); end
    if (held_cnt == 0) begin errors++; $display("FAIL tog_stalls got=0 exp=nonzero"); end
  endtask
  task automatic test_single_beat();
    do_reset(1'b1);
    npk[2] = 1; len[2] = 1;
    drive();
    step();
    npk[1] = 1; len[1] = 2;
    run(40);
    checks += 3;
    if (grants.size() != 2 || grants[0] != 2 || grants[1] != 1) begin errors++; $display("FAIL sb_order got=%0d exp=2", grants.size()); end
    if (starts.size() != 2 || starts[0] != 1 || starts[1] != 3) begin errors++; $display("FAIL sb_starts got=%0d exp=2", starts.size()); end
    if (busyq.size() < 4 || busyq[1] != 1 || busyq[2] != 0 || busyq[3] != 1) begin
      errors++; $display("FAIL sb_busy got=%0d%0d%0d exp=101", busyq[1], busyq[2], busyq[3]);
    end
  endtask
  task automatic test_reset_mid();
    int c = 0;
    do_reset(1'b0);
    npk[1] = 1; len[1] = 6; npk[2] = 1; len[2] = 3;
    drive();
    while (acc[1] < 1 && c < 20) begin step(); c++; end
    #2;
    checks++;
    if (a_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got=%b exp=1", a_valid); end
    rst_n = 1'b0;
    #1;
    checks += 7;
    if (a_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got=%b exp=0", a_valid); end
    if (a_last !== 1'b0) begin errors++; $display("FAIL mid_last got=%b exp=0", a_last); end
    if (a_data !== '0) begin errors++; $display("FAIL mid_data got=%h exp=0", a_data); end
    if (a_ready !== '0) begin errors++; $display("FAIL mid_ready got=%b exp=0", a_ready); end
    if (a_busy !== 1'b0) begin errors++; $display("FAIL mid_busy got=%b exp=0", a_busy); end
    if (a_done !== 1'b0) begin errors++; $display("FAIL mid_done got=%b exp=0", a_done); end
    if (a_id !== '0) begin errors++; $display("FAIL mid_id got=%0d exp=0", a_id); end
    do_reset(1'b0);
    npk[2] = 1; len[2] = 2; npk[1] = 1; len[1] = 2;
    drive();
    run(60);
    checks++;
    if (grants.size() != 2 || grants[0] != 1 || grants[1] != 2) begin errors++; $display("FAIL mid_regrant got=%0d exp=1", grants.size() > 0 ? grants[0] : -1); end
  endtask
  task automatic test_random();
    int tot;
    for (int s = 0; s < 2; s++) begin
      do_reset(s[0]);
      rnd_len = 1'b1; rnd_rdy = 1'b1;
      tot = 0;
      for (int i = 0; i < N; i++) begin npk[i] = $urandom_range(1, 4); tot += npk[i]; end
      drive();
      run(600);
      checks++;
      if (n_done != tot) begin errors++; $display("FAIL rand%0d_pkts got=%0d exp=%0d", s, n_done, tot); end
    end
  endtask
  initial begin
    test_reset();
    test_round_robin();
    test_priority();
    test_valid_drop();
    test_ready_toggle();
    test_single_beat();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
